// File: rtl/dac8_stream_out.sv
// dac8_stream_out: takes samples from a valid/ready stream into a FIFO and plays them out to an 8-bit parallel DAC.
// It also generates the DAC clock. Define DAC8_UNDERFLOW_COUNT_EN to enable the saturating underflow counter.
module dac8_stream_out #(
  parameter int         CLK_DIV     = 4,
  parameter int         FIFO_DEPTH  = 8,
  parameter int         PRIME_LEVEL = 2,
  parameter logic [7:0] IDLE_CODE   = 8'h80
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_en,
  input  logic [7:0]                  i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic [7:0]                  o_dac_data,
  output logic                        o_dac_clk,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_underflow,
  output logic [15:0]                 o_underflow_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV / 2);
  localparam logic [DW-1:0] DIV_SLOT  = DW'(CLK_DIV / 2 - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_PRIME = LW'(PRIME_LEVEL);

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} state_t;

  state_t        r_state, w_stateNext;
  logic [DW-1:0] r_divCnt, w_divNext;
  logic          r_dacClk, w_dacClkNext;
  logic [7:0]    r_dacData, w_dataNext;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wrPtr, r_rdPtr;
  logic [LW-1:0] r_level;
  logic          r_underflow;
  logic          w_push, w_pop, w_starved, w_slot, w_wrap;

  assign o_ready     = (r_level != LVL_FULL);
  assign w_push      = i_valid & o_ready;
  assign w_slot      = (r_state != ST_IDLE) && (r_divCnt == DIV_SLOT);
  assign w_wrap      = (r_state != ST_IDLE) && (r_divCnt == DIV_LAST);
  assign o_dac_data  = r_dacData;
  assign o_dac_clk   = r_dacClk;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_level     = r_level;
  assign o_underflow = r_underflow;

  always_comb begin
    w_stateNext = r_state;
    w_divNext   = r_divCnt;
    w_dataNext  = r_dacData;
    w_pop       = 1'b0;
    w_starved   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_divNext  = '0;
        w_dataNext = IDLE_CODE;
        if (i_en) w_stateNext = ST_PRIME;
      end
      ST_PRIME: begin
        w_divNext = w_wrap ? '0 : r_divCnt + DW'(1);
        if (w_slot && (r_level >= LVL_PRIME)) begin
          w_pop       = 1'b1;
          w_dataNext  = r_mem[r_rdPtr];
          w_stateNext = ST_RUN;
        end
      end
      ST_RUN: begin
        w_divNext = w_wrap ? '0 : r_divCnt + DW'(1);
        if (w_slot) begin
          if (r_level != '0) begin
            w_pop      = 1'b1;
            w_dataNext = r_mem[r_rdPtr];
          end else begin
            w_starved = 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_divNext   = '0;
      end
    endcase
    // A disable only lands on the wrap edge, so the final DAC period is never truncated.
    if (w_wrap && !i_en) begin
      w_stateNext = ST_IDLE;
      w_divNext   = '0;
      w_dataNext  = IDLE_CODE;
    end
    w_dacClkNext = (w_stateNext != ST_IDLE) && (w_divNext < DIV_HALF);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_divCnt    <= '0;
      r_dacClk    <= 1'b0;
      r_dacData   <= IDLE_CODE;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_level     <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_divCnt    <= w_divNext;
      r_dacClk    <= w_dacClkNext;
      r_dacData   <= w_dataNext;
      r_underflow <= w_starved;
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset; the reset level and pointers already make it empty.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wrPtr] <= i_data;
  end

`ifdef DAC8_UNDERFLOW_COUNT_EN
  logic [15:0] r_ufCnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ufCnt <= 16'h0000;
    end else if ((r_state == ST_IDLE) && i_en) begin
      r_ufCnt <= 16'h0000;
    end else if (w_starved && (r_ufCnt != 16'hFFFF)) begin
      r_ufCnt <= r_ufCnt + 16'd1;
    end
  end

  assign o_underflow_cnt = r_ufCnt;
`else
  assign o_underflow_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dac8_stream_out.sv
// tb_dac8_stream_out: checks dac8_stream_out using a vector table, directed corner sequences and random traffic.
// The random traffic is compared every cycle against a queue-based reference model.
module tb_dac8_stream_out;

  localparam int         CLK_DIV     = 4;
  localparam int         FIFO_DEPTH  = 8;
  localparam int         PRIME_LEVEL = 2;
  localparam logic [7:0] IDLE_CODE   = 8'h80;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_en;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  o_dac_data;
  logic        o_dac_clk;
  logic        o_busy;
  logic [3:0]  o_level;
  logic        o_underflow;
  logic [15:0] o_underflow_cnt;

  dac8_stream_out #(
    .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .PRIME_LEVEL(PRIME_LEVEL), .IDLE_CODE(IDLE_CODE)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_dac_data(o_dac_data), .o_dac_clk(o_dac_clk), .o_busy(o_busy),
    .o_level(o_level), .o_underflow(o_underflow), .o_underflow_cnt(o_underflow_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model: a sample queue plus the position within the current DAC period.
  logic [7:0] mQ[$];
  bit         mBusy;
  bit         mPrimed;
  int         mPhase;
  logic [7:0] mData;
  bit         mUf;
  int         mUfCnt;

  typedef struct {
    logic       en;
    logic       valid;
    logic [7:0] data;
    logic [3:0] level;
    logic       ready;
    logic       busy;
    logic       dacClk;
    logic [7:0] dacData;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mBusy   = 1'b0;
    mPrimed = 1'b0;
    mPhase  = 0;
    mData   = IDLE_CODE;
    mUf     = 1'b0;
    mUfCnt  = 0;
  endtask

  task automatic modelStep(input logic en, input logic valid, input logic [7:0] data);
    bit pushOk;
    pushOk = valid && (mQ.size() < FIFO_DEPTH);
    mUf = 1'b0;
    if (!mBusy) begin
      if (en) begin
        mBusy   = 1'b1;
        mPrimed = 1'b0;
        mPhase  = 0;
        mUfCnt  = 0;
      end
    end else begin
      mPhase = (mPhase + 1) % CLK_DIV;
      if (mPhase == 0 && !en) begin
        mBusy = 1'b0;
        mData = IDLE_CODE;
      end else if (mPhase == CLK_DIV / 2) begin
        if (!mPrimed) begin
          if (mQ.size() >= PRIME_LEVEL) begin
            mData   = mQ.pop_front();
            mPrimed = 1'b1;
          end
        end else if (mQ.size() > 0) begin
          mData = mQ.pop_front();
        end else begin
          mUf = 1'b1;
          if (mUfCnt < 65535) mUfCnt++;
        end
      end
    end
    if (pushOk) mQ.push_back(data);
  endtask

  task automatic checkModel();
    logic [15:0] expCnt;
`ifdef DAC8_UNDERFLOW_COUNT_EN
    expCnt = 16'(mUfCnt);
`else
    expCnt = 16'h0000;
`endif
    checkOutput("mdlData",  16'(o_dac_data),  16'(mData));
    checkOutput("mdlClk",   16'(o_dac_clk),   16'(mBusy && (mPhase < CLK_DIV / 2)));
    checkOutput("mdlBusy",  16'(o_busy),      16'(mBusy));
    checkOutput("mdlLevel", 16'(o_level),     16'(mQ.size()));
    checkOutput("mdlReady", 16'(o_ready),     16'(mQ.size() < FIFO_DEPTH));
    checkOutput("mdlUf",    16'(o_underflow), 16'(mUf));
    checkOutput("mdlUfCnt", o_underflow_cnt,  expCnt);
  endtask

  task automatic applyStimulus(input logic en, input logic valid, input logic [7:0] data);
    i_en    = en;
    i_valid = valid;
    i_data  = data;
    @(posedge i_clk);
    modelStep(en, valid, data);
    #1;
    checkModel();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "Clk"},   16'(o_dac_clk),   16'h0);
    checkOutput({tag, "Data"},  16'(o_dac_data),  16'(IDLE_CODE));
    checkOutput({tag, "Ready"}, 16'(o_ready),     16'h1);
    checkOutput({tag, "Busy"},  16'(o_busy),      16'h0);
    checkOutput({tag, "Level"}, 16'(o_level),     16'h0);
    checkOutput({tag, "Uf"},    16'(o_underflow), 16'h0);
    checkOutput({tag, "UfCnt"}, o_underflow_cnt,  16'h0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] playOrder [8];
    logic [7:0] firstSample;
    logic       rEn;
    int         pushThresh;

    i_rst_n = 1'b0;
    i_en    = 1'b0;
    i_valid = 1'b0;
    i_data  = 8'h00;
    modelReset();
    repeat (2) @(posedge i_clk);
    #1;
    checkResetValues("rstHold");
    i_rst_n = 1'b1;
    #1;
    checkResetValues("rstRel");

    // Fill the FIFO while idle; the ninth push must be refused.
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{en: 1'b0, valid: 1'b1, data: 8'((i + 1) * 8'h11), level: 4'(i + 1),
                  ready: (i != 7), busy: 1'b0, dacClk: 1'b0, dacData: IDLE_CODE};
    end
    vecs[8] = '{en: 1'b0, valid: 1'b1, data: 8'h99, level: 4'd8,
                ready: 1'b0, busy: 1'b0, dacClk: 1'b0, dacData: IDLE_CODE};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].en, vecs[i].valid, vecs[i].data);
      checkOutput("tblLevel", 16'(o_level),    16'(vecs[i].level));
      checkOutput("tblReady", 16'(o_ready),    16'(vecs[i].ready));
      checkOutput("tblBusy",  16'(o_busy),     16'(vecs[i].busy));
      checkOutput("tblClk",   16'(o_dac_clk),  16'(vecs[i].dacClk));
      checkOutput("tblData",  16'(o_dac_data), 16'(vecs[i].dacData));
    end

    // Enable and expect one queued sample per update slot, in push order.
    for (int i = 0; i < 8; i++) playOrder[i] = 8'((i + 1) * 8'h11);
    for (int k = 0; k < 8; k++) begin
      repeat ((k == 0) ? 3 : 4) applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("slotData",  16'(o_dac_data), 16'(playOrder[k]));
      checkOutput("slotLevel", 16'(o_level),    16'(7 - k));
      checkOutput("slotReady", 16'(o_ready),    16'h1);
    end

    // Starved slots hold the last sample and pulse underflow for exactly one cycle.
    for (int s = 1; s <= 3; s++) begin
      repeat ((s == 1) ? 4 : 3) applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("starveData", 16'(o_dac_data),  16'h88);
      checkOutput("starveUf",   16'(o_underflow), 16'h1);
`ifdef DAC8_UNDERFLOW_COUNT_EN
      checkOutput("starveCnt",  o_underflow_cnt,  16'(s));
`else
      checkOutput("starveCnt",  o_underflow_cnt,  16'h0);
`endif
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("starveUfEnd", 16'(o_underflow), 16'h0);
    end

    // Disable during the high phase: the period completes and then the stream idles.
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("disHighClk",  16'(o_dac_clk), 16'h1);
    checkOutput("disHighBusy", 16'(o_busy),    16'h1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("disLowBusy",  16'(o_busy),    16'h1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("disBusy",     16'(o_busy),     16'h0);
    checkOutput("disClk",      16'(o_dac_clk),  16'h0);
    checkOutput("disData",     16'(o_dac_data), 16'(IDLE_CODE));
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);

    // A brief enable drop that recovers before the wrap must not stop the stream.
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("cancelBusy", 16'(o_busy),    16'h1);
    checkOutput("cancelClk",  16'(o_dac_clk), 16'h1);
    repeat (4) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("cancelIdle", 16'(o_busy), 16'h0);

    // Reach RUN with five samples left, then reset asynchronously.
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 8'(8'hA0 + i));
    repeat (7) applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("preRstLevel", 16'(o_level),    16'h5);
    checkOutput("preRstData",  16'(o_dac_data), 16'hA1);
    applyStimulus(1'b1, 1'b0, 8'h00);
    i_rst_n = 1'b0;
    #1;
    checkResetValues("midRst");
    modelReset();
    #1;
    i_rst_n = 1'b1;

    // After reset the stream waits in PRIME at idle code until two samples are queued.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("primeWaitData", 16'(o_dac_data), 16'(IDLE_CODE));
      checkOutput("primeWaitBusy", 16'(o_busy),     16'h1);
    end
    firstSample = 8'h5A;
    applyStimulus(1'b1, 1'b1, firstSample);
    applyStimulus(1'b1, 1'b1, 8'hC3);
    checkOutput("primeHoldData", 16'(o_dac_data), 16'(IDLE_CODE));
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("primeFirstData",  16'(o_dac_data), 16'(firstSample));
    checkOutput("primeFirstLevel", 16'(o_level),    16'h1);

    // Random traffic with shifting push density and occasional enable toggles.
    rEn = 1'b1;
    pushThresh = 4;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) pushThresh = $urandom_range(1, 7);
      if ($urandom_range(0, 39) == 0) rEn = ~rEn;
      applyStimulus(rEn, ($urandom_range(0, 7) < pushThresh), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
